// File: rtl/btn_debounce_pkg.sv
// Shared types and constant helpers for the front-panel button debouncer.
package btn_debounce_pkg;

  // Per-button auto-repeat state.
  typedef enum logic [1:0] {
    REL    = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_t;

  // Ceiling log2, used to size counters that must hold the value (v-1).
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: debounce counter, auto-repeat FSM and registered press/release pulses.
module btn_channel
  import btn_debounce_pkg::*;
#(
  parameter int STABLE       = 4,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic strobe,
  input  logic din,
  output logic btn_state,
  output logic btn_press,
  output logic btn_release
);

  localparam int CW = clog2(STABLE + 1);
  localparam int RW = clog2(max2(REPEAT_DELAY, REPEAT_RATE) + 1);

  localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [RW-1:0] RPT_DELAY = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] RPT_RATE  = RW'(REPEAT_RATE);
  localparam logic [RW-1:0] RPT_ONE   = RW'(1);

  logic [CW-1:0] cnt;
  logic [RW-1:0] rpt;
  rpt_state_t    fsm;
  logic          differs;
  logic          accept;

  assign differs = (din != btn_state);
  assign accept  = differs && (cnt == CNT_LAST);

  // Debounce and repeat FSM: everything advances only on the sample strobe;
  // an accepted edge takes priority over the repeat countdown in the same strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      rpt         <= '0;
      fsm         <= REL;
      btn_state   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      if (strobe) begin
        if (!differs) begin
          cnt <= '0;
        end else if (accept) begin
          cnt       <= '0;
          btn_state <= din;
          if (din) begin
            btn_press <= 1'b1;
            fsm       <= DELAY;
            rpt       <= RPT_DELAY;
          end else begin
            btn_release <= 1'b1;
            fsm         <= REL;
            rpt         <= '0;
          end
        end else begin
          cnt <= cnt + CNT_ONE;
        end

        // A zero reload (REPEAT_DELAY = 0) parks the FSM in DELAY with no repeats.
        if (btn_state && !accept && (fsm != REL) && (rpt != '0)) begin
          if (rpt == RPT_ONE) begin
            btn_press <= 1'b1;
            rpt       <= RPT_RATE;
            fsm       <= REPEAT;
          end else begin
            rpt <= rpt - RPT_ONE;
          end
        end
      end
    end
  end

endmodule

// File: rtl/btn_debounce.sv
// Front-panel button debouncer: input synchronizers, sample strobe from the
// divider's slow square wave, and one independent channel per button.
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int N            = 4,
  parameter int STABLE       = 4,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic [N-1:0] btn_raw,
  output logic [N-1:0] btn_state,
  output logic [N-1:0] btn_press,
  output logic [N-1:0] btn_release
);

  logic [N-1:0] sync_p0;
  logic [N-1:0] sync_p1;
  logic         tick_q;
  logic         tick_arm;
  logic         strobe;

  // tick_arm blocks the strobe until tick has been seen low after reset, so a
  // tick already high at reset release is not mistaken for a rising edge.
  assign strobe = tick & ~tick_q & tick_arm;

  // Two-flop synchronizer on the raw buttons plus tick edge history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0  <= '0;
      sync_p1  <= '0;
      tick_q   <= 1'b0;
      tick_arm <= 1'b0;
    end else begin
      sync_p0  <= btn_raw;
      sync_p1  <= sync_p0;
      tick_q   <= tick;
      tick_arm <= tick_arm | ~tick;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_chan
    btn_channel #(
      .STABLE      (STABLE),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .strobe     (strobe),
      .din        (sync_p1[i]),
      .btn_state  (btn_state[i]),
      .btn_press  (btn_press[i]),
      .btn_release(btn_release[i])
    );
  end

endmodule
